mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 95 +++++++++
 tb/tb_mult_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one sequential 4x4 multiplier between two requesters
module mult_arbiter #(
  parameter int TIMEOUT = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] m_a,
  output logic [3:0] m_b,
  output logic       m_xs,
  input  logic       m_fin,
  input  logic [7:0] m_mult,
  output logic [7:0] res,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic owner;
  logic last;
  logic win;
  // Winner of this IDLE cycle: a lone requester wins, a tie goes to whoever was not served last
  always_comb win = (req0 && req1) ? ~last : req1;
  // Controller FSM; every output is a register updated on the state transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      m_a   <= '0;
      m_b   <= '0;
      m_xs  <= 1'b0;
      res   <= '0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          owner <= win;
          m_a   <= win ? a1 : a0;
          m_b   <= win ? b1 : b0;
          gnt0  <= ~win;
          gnt1  <= win;
          m_xs  <= 1'b1;
          err   <= 1'b0;
          busy  <= 1'b1;
          state <= START;
        end
        START: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          m_xs  <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (m_fin) begin
          res   <= m_mult;
          done0 <= ~owner;
          done1 <= owner;
          state <= DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed self-checking bench for mult_arbiter with a 3-cycle multiplier model
module tb_mult_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, m_xs, done0, done1, err, busy;
  logic [3:0] m_a, m_b;
  logic       m_fin = 1'b0;
  logic [7:0] m_mult = '0;
  logic [7:0] res;
  logic       hang = 1'b0;
  int         checks = 0;
  int         errors = 0;

  mult_arbiter #(.TIMEOUT(28)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .m_a(m_a), .m_b(m_b), .m_xs(m_xs),
    .m_fin(m_fin), .m_mult(m_mult), .res(res),
    .done0(done0), .done1(done1), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!(done0 || done1) && n < 60) begin
      step();
      n++;
    end
  endtask

  // Sequential multiplier: fin pulse with the product three cycles after the start pulse
  initial begin
    int mcnt;
    logic [7:0] prod;
    mcnt = 0;
    prod = '0;
    forever begin
      step();
      m_fin = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0 && !hang) begin
          m_fin  = 1'b1;
          m_mult = prod;
        end
      end
      if (m_xs) begin
        prod = m_a * m_b;
        mcnt = 3;
      end
      chk("gnt_exclusive", 16'(gnt0 && gnt1), 16'd0);
      chk("done_exclusive", 16'(done0 && done1), 16'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic saw_done;
    step();
    chk("rst_ctrl", 16'({gnt0, gnt1, done0, done1, m_xs, err, busy}), 16'd0);
    chk("rst_res", 16'(res), 16'd0);
    chk("rst_ops", 16'({m_a, m_b}), 16'd0);
    reset = 1'b1;
    // single req0: 14 x 5
    req0 = 1'b1; a0 = 4'd14; b0 = 4'd5;
    step();
    chk("t1_gnt", 16'({gnt0, gnt1}), 16'b10);
    chk("t1_xs", 16'(m_xs), 16'd1);
    chk("t1_ma", 16'(m_a), 16'd14);
    chk("t1_mb", 16'(m_b), 16'd5);
    chk("t1_busy", 16'(busy), 16'd1);
    req0 = 1'b0;
    step();
    chk("t1_wait_pulses", 16'({gnt0, gnt1, m_xs}), 16'd0);
    wait_done(n);
    chk("t1_latency", 16'(n), 16'd3);
    chk("t1_done", 16'({done0, done1}), 16'b10);
    chk("t1_res", 16'(res), 16'd70);
    step();
    chk("t1_idle", 16'({done0, busy}), 16'd0);
    // reset so requester 0 has priority again
    reset = 1'b0;
    step();
    reset = 1'b1;
    // simultaneous pair after reset: req0 first
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd2;
    step();
    chk("t2_gnt_first", 16'({gnt0, gnt1}), 16'b10);
    req0 = 1'b0;
    step();
    wait_done(n);
    chk("t2_done0", 16'({done0, done1}), 16'b10);
    chk("t2_res0", 16'(res), 16'd6);
    step();
    chk("t2_idle_gap", 16'({gnt1, busy}), 16'd0);
    step();
    chk("t2_gnt_second", 16'({gnt0, gnt1}), 16'b01);
    req1 = 1'b0;
    step();
    wait_done(n);
    chk("t2_done1", 16'({done0, done1}), 16'b01);
    chk("t2_res1", 16'(res), 16'd6);
    step();
    // single req0 with the largest operands leaves req0 as last served
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
    step();
    chk("t3_gnt", 16'({gnt0, gnt1}), 16'b10);
    req0 = 1'b0;
    step();
    wait_done(n);
    chk("t3_res_225", 16'(res), 16'd225);
    step();
    // second simultaneous pair: req1 not served last, so it wins
    req0 = 1'b1; a0 = 4'd11; b0 = 4'd1;
    req1 = 1'b1; a1 = 4'd0;  b1 = 4'd10;
    step();
    chk("t4_gnt_first", 16'({gnt0, gnt1}), 16'b01);
    req1 = 1'b0;
    step();
    wait_done(n);
    chk("t4_done1", 16'({done0, done1}), 16'b01);
    chk("t4_res_0", 16'(res), 16'd0);
    step();
    step();
    chk("t4_gnt_second", 16'({gnt0, gnt1}), 16'b10);
    req0 = 1'b0;
    step();
    wait_done(n);
    chk("t4_done0", 16'({done0, done1}), 16'b10);
    chk("t4_res_11", 16'(res), 16'd11);
    step();
    // multiplier never finishes: abort after 28 WAIT cycles
    hang = 1'b1;
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd3;
    step();
    chk("t5_gnt", 16'(gnt0), 16'd1);
    req0 = 1'b0;
    n = 0;
    saw_done = 1'b0;
    do begin
      step();
      n++;
      saw_done = saw_done | done0 | done1;
    end while (busy && n < 60);
    chk("t5_abort_cycles", 16'(n), 16'd29);
    chk("t5_err", 16'(err), 16'd1);
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_no_done", 16'(saw_done), 16'd0);
    chk("t5_res_kept", 16'(res), 16'd11);
    step();
    chk("t5_err_held", 16'(err), 16'd1);
    hang = 1'b0;
    req1 = 1'b1; a1 = 4'd4; b1 = 4'd4;
    step();
    chk("t5_regrant", 16'({gnt0, gnt1}), 16'b01);
    chk("t5_err_clear", 16'(err), 16'd0);
    req1 = 1'b0;
    step();
    wait_done(n);
    chk("t5_res_16", 16'(res), 16'd16);
    step();
    // asynchronous reset in the middle of WAIT
    hang = 1'b1;
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd9;
    step();
    req0 = 1'b0;
    step();
    step();
    chk("t6_in_wait", 16'(busy), 16'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_ctrl", 16'({gnt0, gnt1, done0, done1, m_xs, err, busy}), 16'd0);
    chk("t6_async_res", 16'(res), 16'd0);
    chk("t6_async_ops", 16'({m_a, m_b}), 16'd0);
    step();
    chk("t6_no_done", 16'({done0, done1}), 16'd0);
    reset = 1'b1;
    hang = 1'b0;
    req1 = 1'b1; a1 = 4'd5; b1 = 4'd7;
    step();
    chk("t6_gnt1", 16'({gnt0, gnt1}), 16'b01);
    req1 = 1'b0;
    step();
    wait_done(n);
    chk("t6_done1", 16'({done0, done1}), 16'b01);
    chk("t6_res_35", 16'(res), 16'd35);
    step();
    // req1 held through a req0 operation while its operands toggle
    req0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
    req1 = 1'b1; a1 = 4'd1; b1 = 4'd1;
    step();
    chk("t7_gnt0", 16'({gnt0, gnt1}), 16'b10);
    req0 = 1'b0;
    n = 0;
    while (!done0 && n < 60) begin
      a1 = ~a1;
      b1 = b1 + 4'd3;
      step();
      n++;
      chk("t7_ops_stable", 16'({m_a, m_b}), 16'h0067);
    end
    chk("t7_done0", 16'({done0, done1}), 16'b10);
    chk("t7_res_42", 16'(res), 16'd42);
    a1 = 4'd2; b1 = 4'd8;
    step();
    chk("t7_idle_gap", 16'({gnt1, busy}), 16'd0);
    step();
    chk("t7_gnt1", 16'({gnt0, gnt1}), 16'b01);
    chk("t7_ops1", 16'({m_a, m_b}), 16'h0028);
    req1 = 1'b0;
    step();
    wait_done(n);
    chk("t7_done1", 16'({done0, done1}), 16'b01);
    chk("t7_res_16", 16'(res), 16'd16);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
